apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
// - APB completer stage directly downstream of the APB master FSM.
// - Consumes PSEL/PENABLE/PWRITE/PADDR/PWDATA and returns PRDATA/PREADY.
// - Holds a DEPTH x DATA_W register file.
// - Inserts WAIT_CYCLES programmable wait states per transfer, to exercise the master's ACCESS-hold path.
// PARAMETERS
// - ADDR_W       8    APB address width
// - DATA_W       8    APB data width
// - DEPTH        16   register-file entries; power of 2, <= 2**ADDR_W
// - WAIT_CYCLES  1    access-phase cycles with PREADY=0 before completion; 0..15
// PORTS
// - PCLK     in   1       single clock, all logic on posedge
// - PRESETn  in   1       reset: synchronous, active-high (1 = reset)
// - PSEL     in   1       slave select from master
// - PENABLE  in   1       access-phase strobe from master
// - PWRITE   in   1       1 = write, 0 = read
// - PADDR    in   ADDR_W  transfer address
// - PWDATA   in   DATA_W  write data
// - PRDATA   out  DATA_W  read data, registered
// - PREADY   out  1       transfer-complete strobe, registered
// - PSLVERR  out  1       error response; present only with APB_SLV_PSLVERR_EN
// BEHAVIOUR
// - Reset (PRESETn=1 at posedge):
//   - state=IDLE; PRDATA=0, PREADY=0, PSLVERR=0, wait counter=0.
//   - All register-file entries cleared to 0.
//   - Reset mid-transfer abandons the transfer; no write occurs.
// - FSM states: IDLE, WAIT, READY.
// - IDLE, edge with PSEL=1 & PENABLE=0 (setup phase):
//   - Latch PADDR, PWRITE, PWDATA; cnt <= WAIT_CYCLES.
//   - If read: PRDATA <= mem[idx].
//   - If WAIT_CYCLES==0: PREADY<=1, go READY; else go WAIT.
// - IDLE, edge with PENABLE=1 and no prior setup: ignored; stay IDLE, PREADY=0.
// - WAIT, edge with PSEL&PENABLE: cnt <= cnt-1; when cnt==1, PREADY<=1 and go READY.
// - READY, edge with PSEL&PENABLE (PREADY=1 visible): transfer completes.
//   - Write: mem[idx] <= latched PWDATA.
//   - PREADY<=0, PSLVERR<=0, go IDLE.
//   - Back-to-back: the master's next setup cycle is then seen in IDLE; no dead cycle is needed.
// - Timing: access phase lasts exactly WAIT_CYCLES+1 cycles; PREADY is high only in the last one.
// - PRDATA:
//   - Holds the read value from setup until the next read setup.
//   - Write transfers leave PRDATA unchanged.
// - Abort: PSEL=0 in WAIT or READY -> go IDLE, PREADY<=0, no write.
// - Index: idx = latched PADDR[$clog2(DEPTH)-1:0]; addresses >= DEPTH alias (wrap) by default.
// - Read of a location written by the immediately preceding transfer returns the new value.
// CONFIGURATION
// - Macro: APB_SLV_PSLVERR_EN.
// - Defined:
//   - PSLVERR port exists.
//   - Latched PADDR >= DEPTH flags an error at setup.
//   - PSLVERR is asserted together with PREADY in the completing cycle.
//   - Write is suppressed; read returns PRDATA=0.
// - Undefined: no PSLVERR port; out-of-range addresses alias per the index rule; no error signalling.
// STRUCTURE
// - Package apb_pkg:
//   - slave state enum (IDLE/WAIT/READY).
//   - APB_ADDR_W/APB_DATA_W defaults.
//   - Constant APB_WRITE=1'b1.
// - Sub-module apb_slv_mem:
//   - DEPTH x DATA_W array, synchronous write, combinational read, synchronous clear on reset.
//   - Instantiated once.
// - FSM, wait counter and output registers live in the top level.
// TESTING
// - Reset: hold PRESETn=1 for 2 cycles -> PRDATA=0, PREADY=0; read of addr 0x05 returns 0x00.
// - Write, then read: WAIT_CYCLES=1.
//   - Write 0xA5 to 0x03 -> PREADY high in 2nd access cycle only.
//   - Read 0x03 -> PRDATA=0xA5.
// - Zero wait: WAIT_CYCLES=0, write 0x3C to 0x0F -> PREADY=1 in the first access cycle; readback 0x3C.
// - Back-to-back: write 0x11 to 0x01 then read 0x01 with no IDLE between -> PRDATA=0x11, no lost cycle.
// - Abort/reset mid-op: PSEL dropped in WAIT during write of 0x77 to 0x02 -> mem[2] stays 0x00.
//   - PRESETn=1 in READY also gives no write.
// - Out of range, DEPTH=16, write 0xEE to 0x13:
//   - Macro off: mem[3]=0xEE.
//   - Macro on: PSLVERR=1 with PREADY; mem[3] unchanged; read of 0x13 gives PRDATA=0x00, PSLVERR=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Purpose : shared types and constants for the APB completer register file.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: completer FSM state enum, default APB address/data widths and
// the PWRITE encoding for a write transfer.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    // PWRITE level that denotes a write transfer.
    localparam logic APB_WRITE = 1'b1;

    // IDLE  : waiting for a setup phase (PSEL=1, PENABLE=0).
    // WAIT  : access phase in progress, PREADY held low.
    // READY : PREADY is high; the next PSEL&PENABLE edge completes the transfer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slv_state_e;

endpackage

// File: rtl/apb_slv_mem.sv
// Purpose : DEPTH x DATA_W storage array behind the APB completer.
// Latency : write takes effect on the next PCLK edge; read is combinational.
// Backpressure: none; the array accepts a write on every cycle we=1.
//
// Ports:
//   clk    in   clock, all state on posedge
//   rst    in   synchronous active-high reset, clears every entry to 0
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  read data, combinational from raddr
module apb_slv_mem #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// Purpose : APB completer fronting a DEPTH x DATA_W register file.
// Latency : access phase is WAIT_CYCLES+1 cycles; PREADY is high only in the last one.
// Backpressure: PREADY held low for WAIT_CYCLES access cycles; PSEL=0 mid-transfer aborts it.
//
// Optional feature macro: APB_SLV_PSLVERR_EN
//   defined   -> PSLVERR port exists; a setup address >= DEPTH is an error:
//                PSLVERR rises with PREADY, the write is dropped, a read returns 0.
//   undefined -> no PSLVERR port; addresses >= DEPTH wrap onto the low index bits.
//
// Ports:
//   PCLK     in   clock, all logic on posedge
//   PRESETn  in   synchronous reset, active HIGH (1 = reset) despite the name
//   PSEL     in   completer select
//   PENABLE  in   access-phase strobe
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   transfer address
//   PWDATA   in   write data
//   PRDATA   out  registered read data, loaded at read setup
//   PREADY   out  registered transfer-complete strobe
//   PSLVERR  out  registered error response (macro-dependent)
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY
`ifdef APB_SLV_PSLVERR_EN
    ,
    output logic              PSLVERR
`endif
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    apb_slv_state_e    state_q,  state_d;
    logic [3:0]        cnt_q,    cnt_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              write_q,  write_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              err_q,    err_d;
`ifdef APB_SLV_PSLVERR_EN
    logic              pslverr_q, pslverr_d;
`endif

    logic              setup_err;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Only the low index bits of the latched address address the array; the
    // rest are kept so the full transfer address is visible in the design.
    logic unused_addr;
    assign unused_addr = ^addr_q;

`ifdef APB_SLV_PSLVERR_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    // Extra top bit so DEPTH == 2**ADDR_W compares correctly.
    assign setup_err = ({1'b0, PADDR} >= DEPTH_LIM);
`else
    assign setup_err = 1'b0;
`endif

    // Read port follows the live setup address so PRDATA can be loaded on the
    // setup edge; write port uses the latched address at completion.
    apb_slv_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (PCLK),
        .rst   (PRESETn),
        .we    (mem_we),
        .waddr (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .raddr (PADDR[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        err_d     = err_q;
`ifdef APB_SLV_PSLVERR_EN
        pslverr_d = pslverr_q;
`endif
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                // PENABLE without a preceding setup lands here and is ignored.
                pready_d  = 1'b0;
`ifdef APB_SLV_PSLVERR_EN
                pslverr_d = 1'b0;
`endif
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    cnt_d   = WAIT_INIT;
                    err_d   = setup_err;
                    if (PWRITE != APB_WRITE) begin
                        prdata_d = setup_err ? '0 : mem_rdata;
                    end
                    if (WAIT_CYCLES == 0) begin
                        pready_d  = 1'b1;
`ifdef APB_SLV_PSLVERR_EN
                        pslverr_d = setup_err;
`endif
                        state_d   = READY;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (!PSEL) begin
                    pready_d = 1'b0;
                    state_d  = IDLE;
                end else if (PENABLE) begin
                    cnt_d = cnt_q - 4'd1;
                    // cnt==1 here means this was the last low-PREADY cycle.
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
`ifdef APB_SLV_PSLVERR_EN
                        pslverr_d = err_q;
`endif
                        state_d   = READY;
                    end
                end
            end

            READY: begin
                if (!PSEL) begin
                    pready_d  = 1'b0;
`ifdef APB_SLV_PSLVERR_EN
                    pslverr_d = 1'b0;
`endif
                    state_d   = IDLE;
                end else if (PENABLE) begin
                    // Completion: commit the write unless the setup flagged an error.
                    mem_we    = (write_q == APB_WRITE) && !err_q;
                    pready_d  = 1'b0;
`ifdef APB_SLV_PSLVERR_EN
                    pslverr_d = 1'b0;
`endif
                    state_d   = IDLE;
                end
            end

            default: begin
                pready_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef APB_SLV_PSLVERR_EN
            pslverr_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            err_q     <= err_d;
`ifdef APB_SLV_PSLVERR_EN
            pslverr_q <= pslverr_d;
`endif
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
`ifdef APB_SLV_PSLVERR_EN
    assign PSLVERR = pslverr_q;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Purpose : self-checking bench for apb_slave_regfile; two instances, zero and one wait state.
// Latency : n/a.
// Backpressure: bench master holds the access phase until PREADY, bounded by a cycle budget.
module tb_apb_slave_regfile;

    localparam int DEPTH = 16;
`ifdef APB_SLV_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       psel    [2];
    logic       penable [2];
    logic       pwrite  [2];
    logic [7:0] paddr   [2];
    logic [7:0] pwdata  [2];
    logic [7:0] prdata  [2];
    logic       pready  [2];
`ifdef APB_SLV_PSLVERR_EN
    logic       pslverr [2];
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: plain storage per instance plus last read value.
    logic [7:0] model_mem [2][DEPTH];
    logic [7:0] last_rd   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: WAIT_CYCLES=0, instance 1: WAIT_CYCLES=1.
    apb_slave_regfile #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK    (clk),
        .PRESETn (rst),
        .PSEL    (psel[0]),
        .PENABLE (penable[0]),
        .PWRITE  (pwrite[0]),
        .PADDR   (paddr[0]),
        .PWDATA  (pwdata[0]),
        .PRDATA  (prdata[0]),
        .PREADY  (pready[0])
`ifdef APB_SLV_PSLVERR_EN
        ,
        .PSLVERR (pslverr[0])
`endif
    );

    apb_slave_regfile #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(1)) u_dut1 (
        .PCLK    (clk),
        .PRESETn (rst),
        .PSEL    (psel[1]),
        .PENABLE (penable[1]),
        .PWRITE  (pwrite[1]),
        .PADDR   (paddr[1]),
        .PWDATA  (pwdata[1]),
        .PRDATA  (prdata[1]),
        .PREADY  (pready[1])
`ifdef APB_SLV_PSLVERR_EN
        ,
        .PSLVERR (pslverr[1])
`endif
    );

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    function automatic bit exp_err(input logic [7:0] a);
        return ERR_EN && (int'(a) >= DEPTH);
    endfunction

    function automatic logic [7:0] model_read(input int d, input logic [7:0] a);
        return exp_err(a) ? 8'h00 : model_mem[d][int'(a) % DEPTH];
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = 8'h00;
            for (int i = 0; i < DEPTH; i++) model_mem[d][i] = 8'h00;
        end
    endtask

    task automatic bus_idle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    // One transfer, starting just after a falling edge. Returns number of
    // access cycles up to and including the PREADY cycle (0 on timeout),
    // data/err sampled in that cycle, and PREADY one cycle later.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] v,
                        output logic [7:0] rd, output int acc, output logic err, output logic rdy_after);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = a;
        pwdata[d]  = v;
        @(negedge clk);
        penable[d] = 1'b1;
        acc = 0;
        for (int n = 1; n <= 40 && acc == 0; n++) begin
            if (pready[d] === 1'b1) acc = n;
            else @(negedge clk);
        end
        rd = prdata[d];
`ifdef APB_SLV_PSLVERR_EN
        err = pslverr[d];
`else
        err = 1'b0;
`endif
        @(negedge clk);
        rdy_after = pready[d];
    endtask

    // Transfer plus all model checks; leaves the bus selected for back-to-back use.
    task automatic do_op(input int d, input bit wr, input logic [7:0] a, input logic [7:0] v,
                         input string tag, output logic [7:0] rd);
        logic [7:0] exp_rd;
        logic       e, ra;
        int         acc;
        exp_rd = wr ? last_rd[d] : model_read(d, a);
        xfer(d, wr, a, v, rd, acc, e, ra);
        chk(tag, "acc_cycles", acc, d + 1);
        chk(tag, "prdata", rd, exp_rd);
        chk(tag, "pready_after", ra, 1'b0);
`ifdef APB_SLV_PSLVERR_EN
        chk(tag, "pslverr", e, exp_err(a));
`else
        if (e !== 1'b0) begin
            chk(tag, "pslverr", e, 1'b0);
        end
`endif
        if (wr && !exp_err(a)) model_mem[d][int'(a) % DEPTH] = v;
        if (!wr) last_rd[d] = exp_rd;
    endtask

    initial begin
        logic [7:0] rd;
        longint     t0;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            bus_idle(d);
            pwrite[d] = 1'b0;
            paddr[d]  = 8'h00;
            pwdata[d] = 8'h00;
        end
        model_clear();

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset", "prdata", prdata[d], 8'h00);
            chk("reset", "pready", pready[d], 1'b0);
`ifdef APB_SLV_PSLVERR_EN
            chk("reset", "pslverr", pslverr[d], 1'b0);
`endif
        end
        rst = 1'b0;
        @(negedge clk);
        do_op(1, 1'b0, 8'h05, 8'h00, "reset_rd5", rd);
        chk("reset_rd5", "literal", rd, 8'h00);
        bus_idle(1);
        @(negedge clk);

        // Abort: PSEL dropped while in WAIT during a write of 0x77 to 0x02.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h02; pwdata[1] = 8'h77;
        @(negedge clk);
        chk("abort", "pready_wait", pready[1], 1'b0);
        bus_idle(1);
        @(negedge clk);
        chk("abort", "pready_idle", pready[1], 1'b0);
        do_op(1, 1'b0, 8'h02, 8'h00, "abort_rd", rd);
        chk("abort_rd", "literal", rd, 8'h00);
        bus_idle(1);
        @(negedge clk);

        // Write then read with one wait state.
        do_op(1, 1'b1, 8'h03, 8'hA5, "wr_a5", rd);
        bus_idle(1);
        @(negedge clk);
        do_op(1, 1'b0, 8'h03, 8'h00, "rd_a5", rd);
        chk("rd_a5", "literal", rd, 8'hA5);
        bus_idle(1);
        @(negedge clk);

        // Back-to-back write/read, no idle between: 2 x (setup + 2 access) = 6 cycles.
        t0 = $time;
        do_op(1, 1'b1, 8'h01, 8'h11, "b2b_wr", rd);
        do_op(1, 1'b0, 8'h01, 8'h00, "b2b_rd", rd);
        chk("b2b_rd", "literal", rd, 8'h11);
        chk("b2b", "elapsed_ns", 32'($time - t0), 32'd60);
        bus_idle(1);
        @(negedge clk);

        // Zero wait states.
        do_op(0, 1'b1, 8'h0F, 8'h3C, "zw_wr", rd);
        do_op(0, 1'b0, 8'h0F, 8'h00, "zw_rd", rd);
        chk("zw_rd", "literal", rd, 8'h3C);
        bus_idle(0);
        @(negedge clk);

        // Out-of-range write 0xEE to 0x13: aliases to 3, or errors with the macro.
        do_op(1, 1'b1, 8'h13, 8'hEE, "oor_wr", rd);
        do_op(1, 1'b0, 8'h03, 8'h00, "oor_rd3", rd);
        chk("oor_rd3", "literal", rd, ERR_EN ? 8'hA5 : 8'hEE);
        do_op(1, 1'b0, 8'h13, 8'h00, "oor_rd13", rd);
        chk("oor_rd13", "literal", rd, ERR_EN ? 8'h00 : 8'hEE);
        bus_idle(1);
        @(negedge clk);

        // Randomized traffic on both instances against the model.
        for (int i = 0; i < 120; i++) begin
            int         d;
            bit         wr;
            logic [7:0] a, v;
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 31));
            v  = 8'($urandom_range(0, 255));
            do_op(d, wr, a, v, "rand", rd);
            if ($urandom_range(0, 2) == 0) begin
                bus_idle(d);
                @(negedge clk);
            end
        end
        bus_idle(0);
        bus_idle(1);
        @(negedge clk);

        // Reset while in READY: write of 0x55 to 0x04 must not land.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h04; pwdata[1] = 8'h55;
        @(negedge clk);
        penable[1] = 1'b1;
        @(negedge clk);
        chk("rst_ready", "pready_before", pready[1], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_idle(1);
        model_clear();
        chk("rst_ready", "pready_after", pready[1], 1'b0);
        chk("rst_ready", "prdata_after", prdata[1], 8'h00);
        @(negedge clk);
        do_op(1, 1'b0, 8'h04, 8'h00, "rst_ready_rd", rd);
        chk("rst_ready_rd", "literal", rd, 8'h00);
        bus_idle(1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
